cic_decimator: RTL and testbench

//  Dual-channel (I/Q) 3-stage CIC decimator fed directly by the DDC outputs (i_component/q_component/ddc_valid).

---
 rtl/cic_pkg.sv | 14 +
 rtl/cic_channel.sv | 74 +++++++
 rtl/cic_decimator.sv | 133 +++++++++++++
 tb/tb_cic_decimator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants, accumulator type and shift helper for the dual-channel CIC decimator.
package cic_pkg;
    localparam int N_STG   = 3;
    localparam int MAX_LOG = 6;
    localparam int SMP_W   = 32;
    localparam int ACC_W   = SMP_W + N_STG * MAX_LOG;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Bit growth of an N_STG-stage CIC is N_STG*log2(R); dividing it out exactly restores unity DC gain
    function automatic logic [4:0] shift_amt(input logic [2:0] dec_log2);
        return 5'(dec_log2) * 5'd3;
    endfunction
endpackage

// File: rtl/cic_channel.sv
// One integrator/comb/scaler lane of the CIC decimator; the top instantiates one each for I and Q.
// CIC_ROUND_EN selects round-half-up with positive saturation; otherwise the scaler floors.
module cic_channel
    import cic_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    i_clr,
    input  logic [N_STG-1:0]        i_int_en,
    input  logic [N_STG-1:0]        i_cmb_en,
    input  logic [2:0]              i_dec_log2,
    input  logic signed [IN_W-1:0]  i_x,
    output logic signed [OUT_W-1:0] o_y
);
    acc_t w_x_ext;
    acc_t r_int1_p0, r_int2_p1, r_int3_p2;
    acc_t r_cmb1_p3, r_cmb2_p4, r_cmb3_p5;
    acc_t r_dly1, r_dly2, r_dly3;

`ifdef CIC_ROUND_EN
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};

    function automatic logic signed [OUT_W-1:0] scale(input acc_t v, input logic [4:0] sh);
        logic signed [ACC_W:0] sum;
        sum = {v[ACC_W-1], v} + ({{ACC_W{1'b0}}, 1'b1} << (sh - 5'd1));
        sum = sum >>> sh;
        if (sum > SAT_HI) return OUT_W'(SAT_HI);
        return OUT_W'(sum);
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] scale(input acc_t v, input logic [4:0] sh);
        return OUT_W'(v >>> sh);
    endfunction
`endif

    assign w_x_ext = ACC_W'(i_x);

    // Accumulators wrap modulo 2^ACC_W on purpose; the comb differences undo the wrap exactly
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_int1_p0 <= '0;
            r_int2_p1 <= '0;
            r_int3_p2 <= '0;
            r_cmb1_p3 <= '0;
            r_cmb2_p4 <= '0;
            r_cmb3_p5 <= '0;
            r_dly1    <= '0;
            r_dly2    <= '0;
            r_dly3    <= '0;
        end else begin
            // p0..p2: integrators, each one edge behind the previous
            if (i_int_en[0]) r_int1_p0 <= r_int1_p0 + w_x_ext;
            if (i_int_en[1]) r_int2_p1 <= r_int2_p1 + r_int1_p0;
            if (i_int_en[2]) r_int3_p2 <= r_int3_p2 + r_int2_p1;
            // p3..p5: combs at the decimated rate
            if (i_cmb_en[0]) begin
                r_cmb1_p3 <= r_int3_p2 - r_dly1;
                r_dly1    <= r_int3_p2;
            end
            if (i_cmb_en[1]) begin
                r_cmb2_p4 <= r_cmb1_p3 - r_dly2;
                r_dly2    <= r_cmb1_p3;
            end
            if (i_cmb_en[2]) begin
                r_cmb3_p5 <= r_cmb2_p4 - r_dly3;
                r_dly3    <= r_cmb2_p4;
            end
        end
    end

    assign o_y = scale(r_cmb3_p5, shift_amt(i_dec_log2));
endmodule

// File: rtl/cic_decimator.sv
// Dual-channel (I/Q) 3-stage CIC decimator, R = 2^dec_log2, with a 2-entry FWFT output FIFO.
// Define CIC_ROUND_EN for round-half-up output scaling instead of truncation.
module cic_decimator
    import cic_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  i_in,
    input  logic signed [IN_W-1:0]  q_in,
    input  logic                    in_valid,
    input  logic [2:0]              dec_log2,
    input  logic                    cfg_load,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    input  logic                    clr_overflow
);
    logic [2:0] r_dec;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_max;
    logic       w_acc, w_strobe, w_clr;
    logic       r_vld_p1, r_vld_p2;
    logic       r_str_p1, r_str_p2, r_str_p3, r_str_p4, r_str_p5, r_str_p6;
    logic signed [OUT_W-1:0] w_y_i, w_y_q;
    logic signed [OUT_W-1:0] r_hd_i, r_hd_q, r_tl_i, r_tl_q;
    logic [1:0] r_occ, w_occ_pop;
    logic       w_pop, w_wr, w_drop;

    function automatic logic [2:0] clamp_log2(input logic [2:0] d);
        if (d == 3'd0) return 3'd1;
        if (d > 3'(MAX_LOG)) return 3'(MAX_LOG);
        return d;
    endfunction

    // cfg_load wins over a coincident sample: it is neither integrated nor counted
    assign w_clr     = rst | cfg_load;
    assign w_acc     = in_valid & ~cfg_load;
    assign w_cnt_max = 6'((7'd1 << r_dec) - 7'd1);
    assign w_strobe  = w_acc & (r_cnt == w_cnt_max);

    always_ff @(posedge clk) begin
        if (rst)           r_dec <= 3'd1;
        else if (cfg_load) r_dec <= clamp_log2(dec_log2);
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_cnt    <= '0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_str_p1 <= 1'b0;
            r_str_p2 <= 1'b0;
            r_str_p3 <= 1'b0;
            r_str_p4 <= 1'b0;
            r_str_p5 <= 1'b0;
            r_str_p6 <= 1'b0;
        end else begin
            if (w_acc) r_cnt <= w_strobe ? 6'd0 : r_cnt + 6'd1;
            r_vld_p1 <= w_acc;
            r_vld_p2 <= r_vld_p1;
            r_str_p1 <= w_strobe;
            r_str_p2 <= r_str_p1;
            r_str_p3 <= r_str_p2;
            r_str_p4 <= r_str_p3;
            r_str_p5 <= r_str_p4;
            r_str_p6 <= r_str_p5;
        end
    end

    cic_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_chan_i (
        .clk        (clk),
        .i_clr      (w_clr),
        .i_int_en   ({r_vld_p2, r_vld_p1, w_acc}),
        .i_cmb_en   ({r_str_p5, r_str_p4, r_str_p3}),
        .i_dec_log2 (r_dec),
        .i_x        (i_in),
        .o_y        (w_y_i)
    );

    cic_channel #(.IN_W(IN_W), .OUT_W(OUT_W)) u_chan_q (
        .clk        (clk),
        .i_clr      (w_clr),
        .i_int_en   ({r_vld_p2, r_vld_p1, w_acc}),
        .i_cmb_en   ({r_str_p5, r_str_p4, r_str_p3}),
        .i_dec_log2 (r_dec),
        .i_x        (q_in),
        .o_y        (w_y_q)
    );

    // p6: FIFO write; a simultaneous pop frees the slot, so a full FIFO only drops without one
    assign out_valid = (r_occ != 2'd0);
    assign w_pop     = out_valid & out_ready;
    assign w_wr      = r_str_p6;
    assign w_occ_pop = r_occ - {1'b0, w_pop};
    assign w_drop    = w_wr & (w_occ_pop == 2'd2);
    assign out_i     = r_hd_i;
    assign out_q     = r_hd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ  <= '0;
            r_hd_i <= '0;
            r_hd_q <= '0;
            r_tl_i <= '0;
            r_tl_q <= '0;
        end else begin
            if (w_pop && r_occ == 2'd2) begin
                r_hd_i <= r_tl_i;
                r_hd_q <= r_tl_q;
            end
            if (w_wr && w_occ_pop == 2'd0) begin
                r_hd_i <= w_y_i;
                r_hd_q <= w_y_q;
            end
            if (w_wr && w_occ_pop == 2'd1) begin
                r_tl_i <= w_y_i;
                r_tl_q <= w_y_q;
            end
            r_occ <= w_occ_pop + {1'b0, w_wr & ~w_drop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)               overflow <= 1'b0;
        else if (w_drop)       overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end
endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator: a direct-form FIR model of the CIC predicts every output.
module tb_cic_decimator;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] i_in = '0, q_in = '0;
    logic               in_valid = 1'b0;
    logic [2:0]         dec_log2 = '0;
    logic               cfg_load = 1'b0;
    logic signed [31:0] out_i, out_q;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               overflow;
    logic               clr_overflow = 1'b0;

    cic_decimator dut (
        .clk(clk), .rst(rst), .i_in(i_in), .q_in(q_in), .in_valid(in_valid),
        .dec_log2(dec_log2), .cfg_load(cfg_load), .out_i(out_i), .out_q(out_q),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] i; logic [31:0] q; } res_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    res_t        exp_q[$];
    logic [31:0] got_i[$], got_q[$];
    longint      hist_i[$], hist_q[$];
    longint      h[$];
    int          m_dec = 1;
    int          m_cnt = 0;
    res_t        mon_e;

    // Impulse response of a 3-stage CIC = three cascaded length-R boxcars
    function automatic void build_h(input int d);
        int r;
        longint t[$];
        r = 1 << d;
        h.delete();
        h.push_back(1);
        repeat (3) begin
            t.delete();
            for (int n = 0; n < h.size() + r - 1; n++) begin
                longint s;
                s = 0;
                for (int k = 0; k < r; k++)
                    if (n - k >= 0 && n - k < h.size()) s += h[n - k];
                t.push_back(s);
            end
            h = t;
        end
    endfunction

    function automatic longint fir(input longint x[$]);
        longint s;
        int n;
        s = 0;
        n = x.size() - 1;
        for (int k = 0; k < h.size() && k <= n; k++) s += h[k] * x[n - k];
        return s;
    endfunction

    function automatic logic [31:0] scale(input longint y, input int s);
        longint t;
`ifdef CIC_ROUND_EN
        t = (y + (longint'(1) <<< (s - 1))) >>> s;
        if (t > 64'sd2147483647) t = 64'sd2147483647;
`else
        t = y >>> s;
`endif
        return t[31:0];
    endfunction

    task automatic model_reset();
        m_dec = 1;
        m_cnt = 0;
        hist_i.delete();
        hist_q.delete();
        exp_q.delete();
        build_h(1);
    endtask

    // Drive one cycle of input; the model advances at the same edge the DUT samples it
    task automatic step(input logic v, input logic signed [31:0] xi, input logic signed [31:0] xq,
                        input logic cfg = 1'b0, input logic [2:0] dl = 3'd0);
        res_t e;
        in_valid = v; i_in = xi; q_in = xq; cfg_load = cfg; dec_log2 = dl;
        @(posedge clk);
        if (cfg) begin
            m_dec = (dl == 3'd0) ? 1 : ((dl > 3'd6) ? 6 : int'(dl));
            m_cnt = 0;
            hist_i.delete();
            hist_q.delete();
            build_h(m_dec);
        end else if (v) begin
            hist_i.push_back(longint'(xi));
            hist_q.push_back(longint'(xq));
            if (m_cnt == (1 << m_dec) - 1) begin
                e.i = scale(fir(hist_i), 3 * m_dec);
                e.q = scale(fir(hist_q), 3 * m_dec);
                exp_q.push_back(e);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0);
    endtask

    task automatic cfg(input logic [2:0] dl);
        step(1'b0, 0, 0, 1'b1, dl);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output got i=%0d q=%0d, none required", out_i, out_q);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_i !== mon_e.i || out_q !== mon_e.q) begin
                    n_fail++;
                    $display("FAIL output got i=%0d q=%0d want i=%0d q=%0d", out_i, out_q,
                             $signed(mon_e.i), $signed(mon_e.q));
                end
            end
            got_i.push_back(out_i);
            got_q.push_back(out_q);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
        n_tests++; if (out_i !== 32'sd0) begin n_fail++; $display("FAIL reset_out_i got %0d want 0", out_i); end
        n_tests++; if (out_q !== 32'sd0) begin n_fail++; $display("FAIL reset_out_q got %0d want 0", out_q); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_dc();
        cfg(3'd2);
        out_ready = 1'b1;
        got_i.delete(); got_q.delete();
        repeat (40) step(1'b1, 1000, -500);
        idle(12);
        n_tests++; if (got_i.size() != 10) begin n_fail++; $display("FAIL dc_count got %0d want 10", got_i.size()); end
        n_tests++;
        if (got_i.size() == 0 || $signed(got_i[got_i.size()-1]) != 1000 || $signed(got_q[got_q.size()-1]) != -500) begin
            n_fail++; $display("FAIL dc_value last output not i=1000 q=-500 (%0d outputs)", got_i.size());
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL dc_missing got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_impulse();
        int want[3];
`ifdef CIC_ROUND_EN
        want = '{2, 1, 0};
`else
        want = '{1, 0, 0};
`endif
        cfg(3'd0);
        out_ready = 1'b1;
        got_i.delete(); got_q.delete();
        step(1'b1, 4, -4);
        repeat (7) step(1'b1, 0, 0);
        idle(10);
        n_tests++;
        if (got_i.size() != 4) begin
            n_fail++; $display("FAIL impulse_count got %0d want 4", got_i.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if ($signed(got_i[k]) != want[k]) begin
                    n_fail++; $display("FAIL impulse_%0d got %0d want %0d", k, $signed(got_i[k]), want[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        res_t hd;
        cfg(3'd1);
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) step(1'b1, k * 300, -k * 111);
        exp_q.delete(exp_q.size() - 1);
        idle(8);
        hd = (exp_q.size() > 0) ? exp_q[0] : '0;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b want 1", overflow); end
        n_tests++; if (out_i !== hd.i || out_q !== hd.q) begin
            n_fail++; $display("FAIL bp_head got %0d want %0d", out_i, $signed(hd.i)); end
        clr_overflow = 1'b1; @(posedge clk); #1; clr_overflow = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_clr got %b want 0", overflow); end
        // Fourth result is dropped on the same edge clr_overflow is held
        step(1'b1, 7000, 70); step(1'b1, -9000, 90);
        exp_q.delete(exp_q.size() - 1);
        repeat (5) @(posedge clk);
        #1; clr_overflow = 1'b1;
        @(posedge clk); #1; clr_overflow = 1'b0;
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_drop_vs_clr got %b want 1", overflow); end
        clr_overflow = 1'b1; @(posedge clk); #1; clr_overflow = 1'b0;
        // Fifth result lands on a full FIFO in the same edge the head is popped
        step(1'b1, 123, -456); step(1'b1, 789, -1011);
        repeat (5) @(posedge clk);
        #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_pop_write got ovf %b want 0", overflow); end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_after_pop got valid %b want 1", out_valid); end
        out_ready = 1'b1;
        idle(4);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain got %0d pending want 0", exp_q.size()); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got valid %b want 0", out_valid); end
    endtask

    task automatic test_cfg_reload();
        int first;
        cfg(3'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) step(1'b1, k * 1000 - 3000, 500 - k * 77);
        idle(10);
        // Load with a coincident sample that must be discarded
        step(1'b1, 32'sh7fff0000, -32'sh10000, 1'b1, 3'd6);
        got_i.delete(); got_q.delete();
        first = -1;
        for (int k = 1; k <= 80; k++) begin
            step(1'b1, 12345, -777);
            if (first < 0 && out_valid === 1'b1) first = k;
        end
        n_tests++; if (first != 70) begin n_fail++; $display("FAIL reload_latency got %0d want 70", first); end
        repeat (192) step(1'b1, 12345, -777);
        idle(10);
        n_tests++;
        if (got_i.size() == 0 || $signed(got_i[got_i.size()-1]) != 12345 || $signed(got_q[got_q.size()-1]) != -777) begin
            n_fail++; $display("FAIL reload_dc last output not i=12345 q=-777 (%0d outputs)", got_i.size());
        end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL reload_missing got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_full_scale();
        cfg(3'd6);
        out_ready = 1'b1;
        got_i.delete(); got_q.delete();
        repeat (320) step(1'b1, 32'sh80000000, 32'sh7fffffff);
        idle(10);
        n_tests++;
        if (got_i.size() != 5 || got_i[4] !== 32'h80000000 || got_q[4] !== 32'h7fffffff) begin
            n_fail++; $display("FAIL full_scale got %0d outputs, last i=%h want 5 outputs, i=80000000",
                               got_i.size(), (got_i.size() > 0) ? got_i[got_i.size()-1] : 32'h0);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        cfg(3'd1);
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) step(1'b1, k * 50, k * 60);
        exp_q.delete(exp_q.size() - 1);
        idle(8);
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rstm_pre_ovf got %b want 1", overflow); end
        out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) step(1'b1, k * 999, -k * 999);
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1; rst = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_valid got %b want 0", out_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstm_ovf got %b want 0", overflow); end
        n_tests++; if (out_i !== 32'sd0) begin n_fail++; $display("FAIL rstm_out_i got %0d want 0", out_i); end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 0, 0);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL rstm_late_output got valid 1 want 0"); end
        // Default ratio after reset is R=2
        step(1'b1, 8, 16);
        repeat (5) step(1'b1, 0, 0);
        idle(10);
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstm_default got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        build_h(1);
        test_reset();
        test_dc();
        test_impulse();
        test_backpressure();
        test_cfg_reload();
        test_full_scale();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
